// File: rtl/membus_bridge.sv
// Single-outstanding bridge from a valid/ready request/response bus to an
// SRAM-style memory port, with wait states, address checking and a response FIFO.
module membus_bridge #(
    parameter int SIZE        = 4096,
    parameter int WAIT_STATES = 0,
    parameter int RSP_DEPTH   = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wstrb,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        mem_rready,
    output logic        mem_wready,
    output logic [29:0] mem_raddr,
    output logic [29:0] mem_waddr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic [31:0] mem_rdata
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] ACCESS  = 2'd1;
    localparam logic [1:0] CAPTURE = 2'd2;

    localparam int PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;

    logic [1:0]  state_reg;
    logic [3:0]  wait_reg;
    logic        write_reg;
    logic        err_reg;
    logic [29:0] addr_reg;
    logic [31:0] wdata_reg;
    logic [3:0]  wstrb_reg;

    logic [32:0] fifo_mem [RSP_DEPTH];
    logic [PW-1:0] rd_ptr_reg;
    logic [PW-1:0] wr_ptr_reg;
    logic [PW:0]   count_reg;

    logic        accept;
    logic        strobe;
    logic        push;
    logic        pop;
    logic [31:0] capture_data;

    assign req_ready = (state_reg == IDLE) && (count_reg < (PW+1)'(RSP_DEPTH));
    assign accept    = req_valid && req_ready;
    // Erroneous requests still walk through ACCESS so latency is uniform.
    assign strobe    = (state_reg == ACCESS) && (wait_reg == 4'd0) && !err_reg;
    assign push      = (state_reg == CAPTURE);
    assign pop       = rsp_valid && rsp_ready;

    assign mem_rready = strobe && !write_reg;
    assign mem_wready = strobe && write_reg;
    assign mem_raddr  = addr_reg;
    assign mem_waddr  = addr_reg;
    assign mem_wdata  = wdata_reg;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_wstrb
            assign mem_wstrb[gi] = mem_wready & wstrb_reg[gi];
        end
    endgenerate

    assign capture_data = (!err_reg && !write_reg) ? mem_rdata : 32'd0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
            wait_reg  <= 4'd0;
            write_reg <= 1'b0;
            err_reg   <= 1'b0;
            addr_reg  <= 30'd0;
            wdata_reg <= 32'd0;
            wstrb_reg <= 4'd0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        write_reg <= req_write;
                        err_reg   <= (req_addr[1:0] != 2'b00) || (req_addr >= 32'(SIZE));
                        addr_reg  <= req_addr[31:2];
                        wdata_reg <= req_wdata;
                        wstrb_reg <= req_wstrb;
                        wait_reg  <= 4'(WAIT_STATES);
                        state_reg <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (wait_reg != 4'd0) begin
                        wait_reg <= wait_reg - 4'd1;
                    end else begin
                        state_reg <= CAPTURE;
                    end
                end
                CAPTURE: state_reg <= IDLE;
                default: state_reg <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Storage needs no reset; count_reg gates every read of it.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr_reg] <= {err_reg, capture_data};
    end

    assign rsp_valid = (count_reg != '0);
    assign {rsp_err, rsp_rdata} = rsp_valid ? fifo_mem[rd_ptr_reg] : 33'd0;

endmodule

// File: tb/tb_membus_bridge.sv
// Scoreboard bench for membus_bridge: three instances (0, 3 and 5 wait states)
// sharing one clock and reset, each with its own byte-strobed memory model.
module tb_membus_bridge;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        req_valid [3];
    logic        req_ready [3];
    logic        req_write [3];
    logic [31:0] req_addr  [3];
    logic [31:0] req_wdata [3];
    logic [3:0]  req_wstrb [3];
    logic        rsp_valid [3];
    logic        rsp_ready [3];
    logic [31:0] rsp_rdata [3];
    logic        rsp_err   [3];
    logic        mem_rready[3];
    logic        mem_wready[3];
    logic [29:0] mem_raddr [3];
    logic [29:0] mem_waddr [3];
    logic [31:0] mem_wdata [3];
    logic [3:0]  mem_wstrb [3];
    logic [31:0] mem_rdata [3];

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_dut
            membus_bridge #(
                .SIZE(4096),
                .WAIT_STATES((gi == 0) ? 0 : ((gi == 1) ? 3 : 5)),
                .RSP_DEPTH(2)
            ) u_dut (
                .clk(clk), .reset(rst),
                .req_valid(req_valid[gi]), .req_ready(req_ready[gi]),
                .req_write(req_write[gi]), .req_addr(req_addr[gi]),
                .req_wdata(req_wdata[gi]), .req_wstrb(req_wstrb[gi]),
                .rsp_valid(rsp_valid[gi]), .rsp_ready(rsp_ready[gi]),
                .rsp_rdata(rsp_rdata[gi]), .rsp_err(rsp_err[gi]),
                .mem_rready(mem_rready[gi]), .mem_wready(mem_wready[gi]),
                .mem_raddr(mem_raddr[gi]), .mem_waddr(mem_waddr[gi]),
                .mem_wdata(mem_wdata[gi]), .mem_wstrb(mem_wstrb[gi]),
                .mem_rdata(mem_rdata[gi])
            );
        end
    endgenerate

    function automatic int ws(input int i);
        return (i == 0) ? 0 : ((i == 1) ? 3 : 5);
    endfunction

    // Memory model: preloaded on the first edge, 1-cycle registered read.
    logic [31:0] mem [3][1024];
    always @(posedge clk) begin
        if (cyc == 0) begin
            mem[0][0]  <= 32'hDEADBEEF;
            mem[0][4]  <= 32'h12345678;
            mem[0][8]  <= 32'hCAFEF00D;
            mem[0][64] <= 32'h11223344;
            mem[1][4]  <= 32'h55AA55AA;
            mem[2][4]  <= 32'h0BADF00D;
            mem[2][5]  <= 32'h13579BDF;
        end
        for (int i = 0; i < 3; i++) begin
            if (mem_wready[i])
                for (int b = 0; b < 4; b++)
                    if (mem_wstrb[i][b])
                        mem[i][mem_waddr[i][9:0]][8*b +: 8] <= mem_wdata[i][8*b +: 8];
            if (mem_rready[i]) mem_rdata[i] <= mem[i][mem_raddr[i][9:0]];
        end
    end

    typedef struct {
        int          inst;
        logic        err;
        logic [31:0] data;
        int          exp_cyc;
        bit          chk_lat;
    } exp_t;
    exp_t sb_q[$];

    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    int          rd_cnt   [3] = '{0, 0, 0};
    int          wr_cnt   [3] = '{0, 0, 0};
    int          rstb_cyc [3] = '{0, 0, 0};
    int          acc_cyc  [3] = '{0, 0, 0};
    int          head_cyc [3] = '{0, 0, 0};
    bit          head_seen[3] = '{0, 0, 0};
    bit          hold_prev[3] = '{0, 0, 0};
    logic [32:0] prev_head[3];
    logic [29:0] rstb_addr[3];
    logic [3:0]  wstb_strb[3];

    // Monitor: strobe bookkeeping and response scoreboard, sampled mid-cycle.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (mem_rready[i]) begin
                rd_cnt[i]++;
                rstb_cyc[i]  = cyc;
                rstb_addr[i] = mem_raddr[i];
            end
            if (mem_wready[i]) begin
                wr_cnt[i]++;
                wstb_strb[i] = mem_wstrb[i];
            end else begin
                chk("wstrb_idle_zero", mem_wstrb[i], 4'd0);
            end
            if (rst) begin
                head_seen[i] = 0;
                hold_prev[i] = 0;
            end else if (!rsp_valid[i]) begin
                chk("rsp_empty_zero", {rsp_err[i], rsp_rdata[i]}, 33'd0);
                hold_prev[i] = 0;
            end else begin
                if (hold_prev[i]) chk("head_hold", {rsp_err[i], rsp_rdata[i]}, prev_head[i]);
                if (!head_seen[i]) begin
                    head_seen[i] = 1;
                    head_cyc[i]  = cyc;
                end
                if (rsp_ready[i]) begin
                    $display("rsp inst=%0d rdata=%h err=%0d cycle=%0d", i, rsp_rdata[i], rsp_err[i], cyc);
                    if (sb_q.size() == 0) begin
                        chk("unexpected_rsp", 1, 0);
                    end else begin
                        exp_t e;
                        e = sb_q.pop_front();
                        chk("rsp_inst", i, e.inst);
                        chk("rsp_rdata", rsp_rdata[i], e.data);
                        chk("rsp_err", rsp_err[i], e.err);
                        if (e.chk_lat) chk("rsp_latency", head_cyc[i], e.exp_cyc);
                    end
                    head_seen[i] = 0;
                    hold_prev[i] = 0;
                end else begin
                    hold_prev[i] = 1;
                    prev_head[i] = {rsp_err[i], rsp_rdata[i]};
                end
            end
        end
    end

    task automatic issue(input int i, input bit wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] strb,
                         input logic e_err, input logic [31:0] e_data, input bit lat);
        int n;
        exp_t e;
        @(posedge clk); #1;
        req_write[i] = wr;
        req_addr[i]  = addr;
        req_wdata[i] = wdata;
        req_wstrb[i] = strb;
        req_valid[i] = 1'b1;
        n = 0;
        @(negedge clk);
        while (!req_ready[i] && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready[i]) begin
            chk("accept_timeout", 0, 1);
        end else begin
            acc_cyc[i] = cyc;
            $display("req inst=%0d %s addr=%h wdata=%h wstrb=%b cycle=%0d",
                     i, wr ? "WR" : "RD", addr, wdata, strb, cyc);
            e.inst = i; e.err = e_err; e.data = e_data;
            e.exp_cyc = cyc + 3 + ws(i); e.chk_lat = lat;
            sb_q.push_back(e);
        end
        @(posedge clk); #1;
        req_valid[i] = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("drain_pending", sb_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int r0, w0, rel, a1, a2;
        bit bad;
        for (int i = 0; i < 3; i++) begin
            req_valid[i] = 0; req_write[i] = 0; req_addr[i] = 0;
            req_wdata[i] = 0; req_wstrb[i] = 0; rsp_ready[i] = 1;
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk("rst_req_ready", req_ready[i], 1);
            chk("rst_rsp_valid", rsp_valid[i], 0);
            chk("rst_rsp_rdata", rsp_rdata[i], 0);
            chk("rst_rsp_err", rsp_err[i], 0);
            chk("rst_mem_rready", mem_rready[i], 0);
            chk("rst_mem_wready", mem_wready[i], 0);
            chk("rst_mem_raddr", mem_raddr[i], 0);
            chk("rst_mem_waddr", mem_waddr[i], 0);
            chk("rst_mem_wdata", mem_wdata[i], 0);
            chk("rst_mem_wstrb", mem_wstrb[i], 0);
        end
        @(posedge clk); #1 rst = 1'b0;

        // Basic read, zero wait states
        r0 = rd_cnt[0];
        issue(0, 0, 32'h10, 32'h0, 4'h0, 0, 32'h12345678, 1);
        drain();
        chk("t1_rstrobe_count", rd_cnt[0] - r0, 1);
        chk("t1_rstrobe_cycle", rstb_cyc[0], acc_cyc[0] + 1);
        chk("t1_raddr", rstb_addr[0], 30'h4);

        // Partial-byte write then readback
        r0 = rd_cnt[0]; w0 = wr_cnt[0];
        issue(0, 1, 32'h100, 32'hAABBCCDD, 4'b0101, 0, 32'h0, 1);
        drain();
        chk("t2_wstrobe_count", wr_cnt[0] - w0, 1);
        chk("t2_rstrobe_count", rd_cnt[0] - r0, 0);
        chk("t2_wstrb", wstb_strb[0], 4'b0101);
        issue(0, 0, 32'h100, 32'h0, 4'h0, 0, 32'h11BB33DD, 1);
        drain();

        // Write with no byte enables is a strobed no-op
        w0 = wr_cnt[0];
        issue(0, 1, 32'h10, 32'hFFFFFFFF, 4'b0000, 0, 32'h0, 1);
        drain();
        chk("t2b_wstrobe_count", wr_cnt[0] - w0, 1);
        chk("t2b_wstrb", wstb_strb[0], 4'b0000);
        issue(0, 0, 32'h10, 32'h0, 4'h0, 0, 32'h12345678, 1);
        drain();

        // Back-pressure: FIFO fills after two, third waits for the first pop
        @(posedge clk); #1 rsp_ready[0] = 1'b0;
        issue(0, 0, 32'h10, 32'h0, 4'h0, 0, 32'h12345678, 0);
        issue(0, 0, 32'h100, 32'h0, 4'h0, 0, 32'h11BB33DD, 0);
        @(posedge clk); #1;
        req_write[0] = 0; req_addr[0] = 32'h20; req_valid[0] = 1;
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (req_ready[0] || !rsp_valid[0]) bad = 1;
        end
        chk("t3_blocked_when_full", bad, 0);
        @(posedge clk); #1 rsp_ready[0] = 1'b1;
        rel = cyc;
        issue(0, 0, 32'h20, 32'h0, 4'h0, 0, 32'hCAFEF00D, 0);
        chk("t3_accept_after_pop", acc_cyc[0], rel + 1);
        drain();

        // Misaligned read and out-of-range write
        r0 = rd_cnt[0]; w0 = wr_cnt[0];
        issue(0, 0, 32'h2, 32'h0, 4'h0, 1, 32'h0, 1);
        issue(0, 1, 32'd4096, 32'h12345678, 4'hF, 1, 32'h0, 1);
        drain();
        chk("t4_no_rstrobe", rd_cnt[0] - r0, 0);
        chk("t4_no_wstrobe", wr_cnt[0] - w0, 0);

        // Reset in the middle of ACCESS (3 wait states)
        r0 = rd_cnt[1];
        @(posedge clk); #1;
        req_write[1] = 0; req_addr[1] = 32'h10; req_valid[1] = 1;
        @(negedge clk);
        chk("t5_ready_before", req_ready[1], 1);
        @(posedge clk); #1 req_valid[1] = 0;
        @(posedge clk); #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        bad = 0;
        repeat (12) begin
            @(negedge clk);
            if (rsp_valid[1]) bad = 1;
        end
        chk("t5_no_rsp", bad, 0);
        chk("t5_no_strobe", rd_cnt[1] - r0, 0);
        chk("t5_ready_after", req_ready[1], 1);
        issue(1, 0, 32'h10, 32'h0, 4'h0, 0, 32'h55AA55AA, 1);
        drain();
        chk("t5_rstrobe_count", rd_cnt[1] - r0, 1);
        chk("t5_rstrobe_cycle", rstb_cyc[1], acc_cyc[1] + 4);

        // Back-to-back reads with 5 wait states
        issue(2, 0, 32'h10, 32'h0, 4'h0, 0, 32'h0BADF00D, 1);
        a1 = acc_cyc[2];
        issue(2, 0, 32'h14, 32'h0, 4'h0, 0, 32'h13579BDF, 1);
        a2 = acc_cyc[2];
        drain();
        chk("t6_accept_spacing", a2 - a1, 8);

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
